// File: rtl/mux8_scan_driver.sv
`timescale 1ns/1ps
// mux8_scan_driver: latches a byte onto the 8:1 mux data lines and walks the
// select across it, one index per HOLD_CYCLES accepted consumer cycles.
module mux8_scan_driver #(
   parameter int HOLD_CYCLES = 1,
   parameter bit LSB_FIRST   = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       abort,
   output logic [7:0] data_out,
   output logic [2:0] sel,
   output logic       bit_valid,
   input  logic       bit_ready,
   output logic       ser_bit,
   output logic       bit_last,
   output logic       done
);

   // state | meaning
   // IDLE  | in_ready high; waiting for a word, data_out keeps the last word
   // SCAN  | stepping sel across data_out, paced by bit_ready

   localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [2:0]      FIRST_IDX = LSB_FIRST ? 3'd0 : 3'd7;
   localparam logic [2:0]      LAST_IDX  = LSB_FIRST ? 3'd7 : 3'd0;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [7:0]      data_nxt;
   logic [2:0]      sel_nxt;
   logic [CW-1:0]   hold_cnt, hold_nxt;
   logic            done_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         data_out <= 8'h00;
         sel      <= 3'b000;
         hold_cnt <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         data_out <= data_nxt;
         sel      <= sel_nxt;
         hold_cnt <= hold_nxt;
         done     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = data_out;
      sel_nxt   = sel;
      hold_nxt  = hold_cnt;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            // abort in IDLE suppresses the handshake even though in_ready is high
            if (in_valid && !abort) begin
               data_nxt  = in_data;
               sel_nxt   = FIRST_IDX;
               hold_nxt  = '0;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               state_nxt = IDLE;
               sel_nxt   = 3'd0;
               hold_nxt  = '0;
            end else if (bit_ready) begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_nxt = '0;
                  if (sel == LAST_IDX) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end else begin
                     sel_nxt = LSB_FIRST ? (sel + 3'd1) : (sel - 3'd1);
                  end
               end else begin
                  hold_nxt = hold_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready  = (state == IDLE);
   assign bit_valid = (state == SCAN);
   assign bit_last  = bit_valid & (sel == LAST_IDX);
   assign ser_bit   = data_out[sel];

endmodule

// File: tb/tb_mux8_scan_driver.sv
`timescale 1ns/1ps
// Scoreboard bench: dut_a is LSB-first with single-cycle hold, dut_b is
// MSB-first holding each index three accepted cycles.
module tb_mux8_scan_driver;

   typedef struct packed {
      logic [2:0] sel;
      logic       ser;
      logic       last;
      logic [7:0] data;
   } bit_t;

   typedef struct packed {
      logic       rdy;
      logic       bv;
      logic       done;
      logic       last;
      logic       ser;
      logic [2:0] sel;
      logic [7:0] data;
   } obs_t;

   logic            clk;
   logic [1:0]      rst, v, ab, br;
   logic [1:0][7:0] din;

   logic       rdy_a, bv_a, ser_a, last_a, done_a;
   logic [2:0] sel_a;
   logic [7:0] dout_a;
   logic       rdy_b, bv_b, ser_b, last_b, done_b;
   logic [2:0] sel_b;
   logic [7:0] dout_b;

   int n_cmp = 0;
   int n_err = 0;

   bit_t       qa[$], qb[$];
   logic [7:0] dqa[$], dqb[$];

   mux8_scan_driver #(.HOLD_CYCLES(1), .LSB_FIRST(1'b1)) dut_a (
      .clk(clk), .reset(rst[0]), .in_valid(v[0]), .in_ready(rdy_a), .in_data(din[0]),
      .abort(ab[0]), .data_out(dout_a), .sel(sel_a), .bit_valid(bv_a), .bit_ready(br[0]),
      .ser_bit(ser_a), .bit_last(last_a), .done(done_a)
   );

   mux8_scan_driver #(.HOLD_CYCLES(3), .LSB_FIRST(1'b0)) dut_b (
      .clk(clk), .reset(rst[1]), .in_valid(v[1]), .in_ready(rdy_b), .in_data(din[1]),
      .abort(ab[1]), .data_out(dout_b), .sel(sel_b), .bit_valid(bv_b), .bit_ready(br[1]),
      .ser_bit(ser_b), .bit_last(last_b), .done(done_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic obs_t obs(input int d);
      obs_t o;
      if (d == 0) o = {rdy_a, bv_a, done_a, last_a, ser_a, sel_a, dout_a};
      else        o = {rdy_b, bv_b, done_b, last_b, ser_b, sel_b, dout_b};
      return o;
   endfunction

   function automatic void push_bit(input int d, input bit_t e);
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
   endfunction

   function automatic void push_done(input int d, input logic [7:0] w);
      if (d == 0) dqa.push_back(w);
      else        dqb.push_back(w);
   endfunction

   // Monitor: every bit_valid cycle consumes one expected entry; every done
   // pulse consumes one expected word-done record.
   always @(negedge clk) begin
      obs_t       o;
      bit_t       e;
      logic [7:0] w;
      for (int d = 0; d < 2; d++) begin
         o = obs(d);
         if (o.bv === 1'b1) begin
            if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
               check($sformatf("unexpected_bit_%0d", d), 32'(o.bv), 32'd0);
            end else begin
               e = (d == 0) ? qa.pop_front() : qb.pop_front();
               check($sformatf("bit_%0d", d), 32'({o.sel, o.ser, o.last, o.data}), 32'(e));
            end
         end
         if (o.done === 1'b1) begin
            if ((d == 0 && dqa.size() == 0) || (d == 1 && dqb.size() == 0)) begin
               check($sformatf("unexpected_done_%0d", d), 32'(o.done), 32'd0);
            end else begin
               w = (d == 0) ? dqa.pop_front() : dqb.pop_front();
               check($sformatf("done_word_%0d", d), 32'(o.data), 32'(w));
               check($sformatf("done_ready_%0d", d), 32'(o.rdy), 32'd1);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one word, pace the consumer (optional stall at stall_idx) and return
   // in the done cycle. noise keeps in_valid high with junk data during the scan.
   task automatic send(input int d, input logic [7:0] word, input int hold, input bit lsb,
                       input int stall_idx, input int stall_len, input bit noise);
      int   idx;
      int   reps;
      obs_t o;
      for (int j = 0; j < 8; j++) begin
         idx  = lsb ? j : 7 - j;
         reps = hold + ((idx == stall_idx) ? stall_len : 0);
         for (int r = 0; r < reps; r++)
            push_bit(d, {3'(idx), word[idx], (idx == (lsb ? 7 : 0)), word});
      end
      push_done(d, word);
      v[d]   = 1'b1;
      din[d] = word;
      tick();
      o = obs(d);
      check("accept_valid", 32'(o.bv), 32'd1);
      check("accept_ready", 32'(o.rdy), 32'd0);
      check("accept_sel", 32'(o.sel), lsb ? 32'd0 : 32'd7);
      if (noise) din[d] = 8'h3C;
      else       v[d]   = 1'b0;
      for (int j = 0; j < 8; j++) begin
         idx = lsb ? j : 7 - j;
         for (int h = 0; h < hold; h++) begin
            if (idx == stall_idx && h == 0 && stall_len > 0) begin
               br[d] = 1'b0;
               repeat (stall_len) tick();
               br[d] = 1'b1;
            end
            tick();
         end
      end
      v[d] = 1'b0;
   endtask

   initial begin
      obs_t o;
      logic [7:0] w;
      rst = 2'b11;
      v   = 2'b00;
      ab  = 2'b00;
      br  = 2'b11;
      din = '0;
      repeat (2) tick();
      rst = 2'b00;
      for (int d = 0; d < 2; d++) begin
         o = obs(d);
         check("reset_ready", 32'(o.rdy), 32'd1);
         check("reset_valid", 32'(o.bv), 32'd0);
         check("reset_sel", 32'(o.sel), 32'd0);
         check("reset_data", 32'(o.data), 32'd0);
         check("reset_done", 32'(o.done), 32'd0);
      end
      tick();

      // basic LSB-first scan
      send(0, 8'h01, 1, 1'b1, -1, 0, 1'b0);
      tick();
      // walking one, back-to-back with in_valid held
      for (int i = 0; i < 8; i++) begin
         w = 8'h01 << i;
         send(0, w, 1, 1'b1, -1, 0, 1'b1);
      end
      tick();
      // in_valid with other data during SCAN is ignored
      send(0, 8'h5A, 1, 1'b1, -1, 0, 1'b1);
      tick();
      // stall four cycles at sel=3
      send(0, 8'hFF, 1, 1'b1, 3, 4, 1'b0);
      tick();

      // abort at sel=5
      for (int j = 0; j < 6; j++) push_bit(0, {3'(j), w[j], 1'b0, 8'h96});
      w = 8'h96;
      qa.delete();
      for (int j = 0; j < 6; j++) push_bit(0, {3'(j), w[j], 1'b0, w});
      v[0] = 1'b1; din[0] = w;
      tick();
      v[0] = 1'b0;
      repeat (5) tick();
      o = obs(0);
      check("pre_abort_sel", 32'(o.sel), 32'd5);
      ab[0] = 1'b1;
      tick();
      ab[0] = 1'b0;
      o = obs(0);
      check("abort_ready", 32'(o.rdy), 32'd1);
      check("abort_sel", 32'(o.sel), 32'd0);
      check("abort_data", 32'(o.data), 32'h96);
      check("abort_valid", 32'(o.bv), 32'd0);
      // abort with in_valid in IDLE: word must not be taken
      ab[0] = 1'b1; v[0] = 1'b1; din[0] = 8'h77;
      tick();
      ab[0] = 1'b0; v[0] = 1'b0;
      o = obs(0);
      check("abort_idle_valid", 32'(o.bv), 32'd0);
      check("abort_idle_data", 32'(o.data), 32'h96);
      repeat (2) tick();

      // reset mid-scan
      w = 8'hC3;
      for (int j = 0; j < 3; j++) push_bit(0, {3'(j), w[j], 1'b0, w});
      v[0] = 1'b1; din[0] = w;
      tick();
      v[0] = 1'b0;
      repeat (2) tick();
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      o = obs(0);
      check("rst_mid_data", 32'(o.data), 32'd0);
      check("rst_mid_sel", 32'(o.sel), 32'd0);
      check("rst_mid_valid", 32'(o.bv), 32'd0);
      check("rst_mid_done", 32'(o.done), 32'd0);
      tick();

      // MSB-first, three cycles per index
      send(1, 8'hA5, 3, 1'b0, -1, 0, 1'b0);
      tick();
      send(1, 8'h3C, 3, 1'b0, 4, 2, 1'b0);
      repeat (4) tick();

      check("bits_left_a", 32'(qa.size()), 32'd0);
      check("bits_left_b", 32'(qb.size()), 32'd0);
      check("dones_left_a", 32'(dqa.size()), 32'd0);
      check("dones_left_b", 32'(dqb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mux8_scan_driver.md
Name: mux8_scan_driver

Overview:
- Upstream feeder for the 8-to-1 multiplexer.
- Accepts an 8-bit word over a valid/ready handshake and holds it on the mux data lines: data_out[0..7] drive i0..i7.
- Steps the 3-bit select through all eight indices, one index per HOLD_CYCLES accepted cycles, turning the mux output into a paced serial bit stream.
- Reports per-bit valid, last-bit and word-done status so a downstream consumer can pace the stream.

Parameters:
- HOLD_CYCLES, 1: accepted (bit_ready-high) cycles each select value is held; legal range >= 1.
- LSB_FIRST, 1: 1 = scan order 0→7; 0 = scan order 7→0.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- in_data  input  8  word to serialise.
- abort  input  1  synchronous scan cancel.
- data_out  output  8  latched word; bit n drives mux input in.
- sel  output  3  mux select (s).
- bit_valid  output  1  sel/ser_bit currently valid.
- bit_ready  input  1  consumer accepts the current bit.
- ser_bit  output  1  data_out[sel], the expected mux output, for checking and for standalone use.
- bit_last  output  1  current index is the final index of the scan.
- done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values, applied at the next edge with reset=1:
  - state = IDLE
  - data_out = 8'h00
  - sel = 3'b000
  - hold counter = 0
  - bit_valid = 0, done = 0
- Output decode:
  - in_ready = (state == IDLE), combinational from state.
  - bit_valid = (state == SCAN).
  - bit_last = bit_valid & (sel == last index).
  - ser_bit is combinational from data_out and sel.
- States: IDLE, SCAN.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: data_out <= in_data; sel <= (LSB_FIRST ? 0 : 7); hold counter <= 0; state <= SCAN.
  - Otherwise data_out and sel hold their values. The last word remains visible on data_out; it is not cleared.
- SCAN:
  - in_ready = 0; any in_valid is ignored.
  - Hold counter increments only on cycles with bit_ready = 1.
  - A step occurs on a cycle with bit_ready = 1 and hold counter == HOLD_CYCLES-1. On a step the hold counter is cleared and sel advances by ±1 according to LSB_FIRST.
  - If the step occurs at the last index (7 for LSB_FIRST = 1, 0 otherwise): state <= IDLE, done <= 1 for exactly one cycle, sel is left at the last index.
- Stall: while bit_ready = 0, sel, hold counter and ser_bit are frozen. There is no timeout.
- Latency:
  - A word accepted at edge k has bit_valid = 1 and sel = first index from cycle k+1.
  - With bit_ready held at 1, SCAN lasts exactly 8*HOLD_CYCLES cycles.
  - done is asserted in the first IDLE cycle, coincident with in_ready = 1.
  - A new word may be accepted in that same cycle. The minimum word-to-word period is 8*HOLD_CYCLES+1 cycles.
- abort:
  - In SCAN: state <= IDLE, sel <= 0, hold counter <= 0; done is not pulsed; data_out retains the aborted word.
  - In IDLE: no effect.
  - abort & in_valid together in IDLE: abort has priority and the word is not accepted (in_ready is still 1, but the handshake is defined as suppressed).
- Priority: reset > abort > handshake/step.
- Reset mid-scan: returns to the reset values at the next edge, with no done pulse.
- Hold counter width: max(1, clog2(HOLD_CYCLES)). With HOLD_CYCLES = 1 every bit_ready cycle is a step.

Test Plan:
- Basic LSB-first scan: HOLD_CYCLES=1, LSB_FIRST=1, in_data=8'b0000_0001, bit_ready=1.
  - Required: sel = 0,1,...,7 on 8 consecutive cycles; ser_bit = 1,0,0,0,0,0,0,0.
  - bit_last=1 only when sel=7; done pulses 1 cycle later; in_ready=1 that cycle.
- Walking one: words 8'h01, 8'h02, ..., 8'h80 back-to-back, with in_valid held and accepted on each done cycle.
  - Required: ser_bit=1 exactly when sel equals the walking-one position; word starts are 9 cycles apart.
- MSB-first with hold: HOLD_CYCLES=3, LSB_FIRST=0, in_data=8'hA5.
  - Required: sel = 7,6,...,0, each held 3 cycles; ser_bit sequence 1,0,1,0,0,1,0,1; SCAN lasts 24 cycles.
- Stall: HOLD_CYCLES=1, in_data=8'hFF, bit_ready=0 for 4 cycles while sel=3.
  - Required: sel stays 3, bit_valid stays 1, no done pulse; the scan completes 4 cycles later than without the stall.
- Abort and reset:
  - abort=1 while sel=5 → next cycle state IDLE, sel=0, in_ready=1, no done pulse, data_out unchanged.
  - reset=1 mid-scan → next cycle data_out=8'h00, sel=0, bit_valid=0.
- Ignored input: in_valid=1 with in_data=8'h3C during SCAN → in_data is not latched and data_out keeps the in-flight word until the scan ends.
